// File: rtl/serial_word_receiver_if.sv
// Output side of the serial word receiver: a WIDTH-bit holding register
// offered to the downstream transmitter under a valid/ready handshake.
interface serial_word_receiver_if #(
    parameter int WIDTH = 32
);
    // Handshake: out_valid high means out_word holds an unconsumed word and
    // out_word stays stable until a rising edge sees out_valid & out_ready;
    // that edge transfers the word. out_ready while out_valid=0 does nothing.
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_word,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel capture: collects WIDTH bits MSB-first while enable_i is
// high and parks each completed word in a valid/ready holding register.
module serial_word_receiver #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic                       in_i,
    input  logic                       clear_overrun_i,
    output logic [$clog2(WIDTH+1)-1:0] bit_count_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    output logic                       state_o,
    serial_word_receiver_if.master     out_if
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    // The MSB of a full-width shifter would never be observed, so only the
    // WIDTH-1 bits that feed the next candidate word are kept.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] candidate;
    logic             complete;
    logic             hold_free;

    assign candidate = {shift_q, in_i};
    assign complete  = enable_i && (count_q == CW'(WIDTH - 1));
    assign hold_free = !valid_q || out_if.out_ready;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
        if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end

        if (enable_i) begin
            shift_d = candidate[WIDTH-2:0];
            if (complete) begin
                count_d = '0;
                state_d = IDLE;
                if (hold_free) begin
                    word_d  = candidate;
                    valid_d = 1'b1;
                end else begin
                    // Set wins over a same-edge clear.
                    overrun_d = 1'b1;
                end
            end else begin
                count_d = count_q + CW'(1);
                state_d = SHIFT;
            end
        end else begin
            count_d = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.out_word  = word_q;
    assign out_if.out_valid = valid_q;
    assign bit_count_o      = count_q;
    assign busy_o           = (count_q != '0);
    assign overrun_o        = overrun_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: a 32-bit and an 8-bit instance
// driven on the falling edge and observed on the following falling edge.
module tb_serial_word_receiver;
    logic       clk;
    logic       reset;
    logic       enable, in_bit, clear_ovr;
    logic [5:0] bit_count;
    logic       busy, overrun, state;

    logic       enable8, in8, clear_ovr8;
    logic [3:0] bit_count8;
    logic       busy8, overrun8, state8;

    int checks = 0;
    int errors = 0;

    serial_word_receiver_if #(.WIDTH(32)) bus ();
    serial_word_receiver_if #(.WIDTH(8))  bus8 ();

    serial_word_receiver #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable),
        .in_i            (in_bit),
        .clear_overrun_i (clear_ovr),
        .bit_count_o     (bit_count),
        .busy_o          (busy),
        .overrun_o       (overrun),
        .state_o         (state),
        .out_if          (bus.master)
    );

    serial_word_receiver #(.WIDTH(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable8),
        .in_i            (in8),
        .clear_overrun_i (clear_ovr8),
        .bit_count_o     (bit_count8),
        .busy_o          (busy8),
        .overrun_o       (overrun8),
        .state_o         (state8),
        .out_if          (bus8.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Drive `nbits` bits of w, MSB first, one per falling edge; ready is held
    // at `rdy` except on the last bit where it takes `last_rdy`.
    task automatic shift_bits(input logic [31:0] w, input int nbits,
                              input logic rdy, input logic last_rdy);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            enable        = 1'b1;
            in_bit        = w[31-i];
            bus.out_ready = (i == nbits - 1) ? last_rdy : rdy;
        end
    endtask

    task automatic go_idle();
        enable        = 1'b0;
        in_bit        = 1'b0;
        bus.out_ready = 1'b0;
        clear_ovr     = 1'b0;
    endtask

    // One cycle with ready high to drain the holding register.
    task automatic drain();
        enable        = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        go_idle();
        enable8 = 1'b0; in8 = 1'b0; clear_ovr8 = 1'b0; bus8.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bit_count !== 6'd0 || bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 ||
            overrun !== 1'b0 || busy !== 1'b0 || state !== 1'b0) begin
            errors++;
            $display("FAIL reset32: cnt=%0d valid=%b word=%h ovr=%b busy=%b st=%b (want all 0)",
                     bit_count, bus.out_valid, bus.out_word, overrun, busy, state);
        end
        checks++;
        if (bit_count8 !== 4'd0 || bus8.out_valid !== 1'b0 || bus8.out_word !== 8'h0 ||
            overrun8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: cnt=%0d valid=%b word=%h ovr=%b (want all 0)",
                     bit_count8, bus8.out_valid, bus8.out_word, overrun8);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        shift_bits(32'hDEADBEEF, 31, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bit_count !== 6'd31 || busy !== 1'b1 || bus.out_valid !== 1'b0 || state !== 1'b1) begin
            errors++;
            $display("FAIL bit31: cnt=%0d busy=%b valid=%b st=%b want 31 1 0 1",
                     bit_count, busy, bus.out_valid, state);
        end
        enable = 1'b1; in_bit = 1'b1;   // last bit of 0xDEADBEEF
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hDEADBEEF || bit_count !== 6'd0 ||
            overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL word_deadbeef: valid=%b word=%h cnt=%0d ovr=%b busy=%b want 1 deadbeef 0 0 0",
                     bus.out_valid, bus.out_word, bit_count, overrun, busy);
        end
        go_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stall_hold: valid=%b word=%h want 1 deadbeef", bus.out_valid, bus.out_word);
        end
        drain();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL consume: valid=%b word=%h want 0 deadbeef", bus.out_valid, bus.out_word);
        end
        bus.out_ready = 1'b1;   // ready with nothing held is harmless
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_ready: valid=%b word=%h want 0 deadbeef", bus.out_valid, bus.out_word);
        end
    endtask

    task automatic test_abort();
        shift_bits(32'hFFFFFFFF, 10, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bit_count !== 6'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_count: cnt=%0d busy=%b want 10 1", bit_count, busy);
        end
        go_idle();
        @(negedge clk);
        checks++;
        if (bit_count !== 6'd0 || busy !== 1'b0 || bus.out_valid !== 1'b0 || state !== 1'b0) begin
            errors++;
            $display("FAIL abort: cnt=%0d busy=%b valid=%b st=%b want 0 0 0 0",
                     bit_count, busy, bus.out_valid, state);
        end
        shift_bits(32'h12345678, 32, 1'b0, 1'b0);
        @(negedge clk);
        go_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h12345678 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: valid=%b word=%h ovr=%b want 1 12345678 0",
                     bus.out_valid, bus.out_word, overrun);
        end
        drain();
    endtask

    task automatic test_overrun();
        shift_bits(32'hA5A5A5A5, 32, 1'b0, 1'b0);
        shift_bits(32'h0F0F0F0F, 32, 1'b0, 1'b0);
        @(negedge clk);
        go_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hA5A5A5A5 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun: valid=%b word=%h ovr=%b want 1 a5a5a5a5 1",
                     bus.out_valid, bus.out_word, overrun);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%b want 1", overrun);
        end
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || bus.out_word !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL clear_overrun: ovr=%b word=%h want 0 a5a5a5a5", overrun, bus.out_word);
        end
        // Clear pulsed on the same edge as a dropped completion: set wins.
        shift_bits(32'h33333333, 32, 1'b0, 1'b0);
        clear_ovr = 1'b1;
        @(negedge clk);
        go_idle();
        checks++;
        if (overrun !== 1'b1 || bus.out_word !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL set_over_clear: ovr=%b word=%h want 1 a5a5a5a5", overrun, bus.out_word);
        end
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
    endtask

    task automatic test_consume_and_complete();
        // Holding register still has 0xA5A5A5A5; ready only on completion edge.
        shift_bits(32'h3C3C5AA5, 32, 1'b0, 1'b1);
        @(negedge clk);
        go_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h3C3C5AA5 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL consume_complete: valid=%b word=%h ovr=%b want 1 3c3c5aa5 0",
                     bus.out_valid, bus.out_word, overrun);
        end
        drain();
    endtask

    task automatic test_async_reset();
        shift_bits(32'h11111111, 32, 1'b0, 1'b0);
        shift_bits(32'h22222222, 32, 1'b0, 1'b0);
        shift_bits(32'h87654321, 17, 1'b0, 1'b0);
        @(negedge clk);
        go_idle();
        checks++;
        if (bit_count !== 6'd17 || overrun !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d ovr=%b valid=%b want 17 1 1",
                     bit_count, overrun, bus.out_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bit_count !== 6'd0 || bus.out_valid !== 1'b0 || overrun !== 1'b0 ||
            bus.out_word !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d valid=%b ovr=%b word=%h busy=%b want 0 0 0 0 0",
                     bit_count, bus.out_valid, overrun, bus.out_word, busy);
        end
        #1 reset = 1'b0;
        shift_bits(32'hCAFEF00D, 32, 1'b0, 1'b0);
        @(negedge clk);
        go_idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 32'hCAFEF00D || overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: valid=%b word=%h ovr=%b want 1 cafef00d 0",
                     bus.out_valid, bus.out_word, overrun);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'h817E;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (bus8.out_valid !== 1'b1 || bus8.out_word !== 8'h81 || bit_count8 !== 4'd0) begin
                    errors++;
                    $display("FAIL b2b_first: valid=%b word=%h cnt=%0d want 1 81 0",
                             bus8.out_valid, bus8.out_word, bit_count8);
                end
            end
            if (i == 9) begin
                checks++;
                if (bus8.out_valid !== 1'b0 || bit_count8 !== 4'd1) begin
                    errors++;
                    $display("FAIL b2b_gap: valid=%b cnt=%0d want 0 1", bus8.out_valid, bit_count8);
                end
            end
            enable8        = 1'b1;
            in8            = stream[15-i];
            bus8.out_ready = 1'b1;
        end
        @(negedge clk);
        enable8 = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_word !== 8'h7E || overrun8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b word=%h ovr=%b want 1 7e 0",
                     bus8.out_valid, bus8.out_word, overrun8);
        end
        @(negedge clk);
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b0 || overrun8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b ovr=%b want 0 0", bus8.out_valid, overrun8);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_abort();
        test_overrun();
        test_consume_and_complete();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel capture stage that sits directly upstream of the serial word transmitter in the JTAG example datapath. It samples one bit per clock while `enable` is high and assembles the bits MSB-first into a WIDTH-bit word. It then presents the word on a valid/ready holding register, from which the transmitter's `in` word is loaded. Partial words are discarded when `enable` drops. A word that completes while the holding register is still occupied raises a sticky overrun flag.

## Interface
- `WIDTH`, default 32: word length in bits; legal range 2..64.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `enable`  input  1  bit strobe; `in` is sampled on every rising edge where `enable`=1.
- `in`  input  1  serial data bit; the first bit of a word is the MSB.
- `out_word`  output  WIDTH  holding register; stable while `out_valid`=1.
- `out_valid`  output  1  `out_word` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts `out_word` on an edge where `out_valid` & `out_ready`.
- `bit_count`  output  $clog2(WIDTH+1)  bits accumulated in the current partial word.
- `busy`  output  1  1 when `bit_count` != 0.
- `overrun`  output  1  sticky; a completed word was dropped.
- `clear_overrun`  input  1  synchronous clear of `overrun`.

## Operation
- Reset values: `shift_reg`=0, `bit_count`=0, `out_word`=0, `out_valid`=0, `overrun`=0, state IDLE.
- States:
  - IDLE (`bit_count`=0)
  - SHIFT (0 < `bit_count` < WIDTH)
- IDLE -> SHIFT on an edge with `enable`=1, except when WIDTH bits complete on that same edge, which cannot happen for WIDTH >= 2.
- SHIFT -> IDLE on either:
  - the edge sampling bit WIDTH (word complete), or
  - any edge with `enable`=0 (abort: `bit_count` <= 0; `shift_reg` contents are don't-care).
- Per enabled edge: `shift_reg` <= {`shift_reg`[WIDTH-2:0], `in`}; `bit_count` <= `bit_count`+1. Arithmetic is unsigned and never exceeds WIDTH-1 in the register.
- Completion edge: the edge where `bit_count`==WIDTH-1 and `enable`=1. Candidate word = {`shift_reg`[WIDTH-2:0], `in`}; `bit_count` <= 0.
  - If the holding register is free, `out_word` <= candidate and `out_valid` <= 1. It is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 on this same edge.
  - Otherwise, the candidate is dropped, `out_word` is unchanged, and `overrun` <= 1.
- Consume edge without completion: `out_valid` & `out_ready` -> `out_valid` <= 0; `out_word` holds its value.
- `out_ready` while `out_valid`=0 has no effect.
- `overrun`:
  - Set has priority over `clear_overrun` on the same edge.
  - Cleared only by `clear_overrun` or `reset`.
- Back-to-back words: with `enable` held high, the edge after completion samples bit 1 (MSB) of the next word. No gap cycle.

## Timing
- Bit sampling: `in` is captured at the rising edge where `enable`=1, with zero-cycle sampling latency.
- Word latency: `out_valid`=1 and the new `out_word` are visible in the cycle immediately after the completion edge. WIDTH enabled edges therefore produce a word.
- `out_valid` remains high across any number of stall cycles; `out_word` does not change while it is high.
- `busy` and `bit_count` are registered and change only at clock edges, or asynchronously on `reset`.
- Reset mid-word or mid-hold: all state returns to reset values asynchronously. Any pending word is lost and `overrun` does not set.
- `enable` dropping on the completion edge itself: not a completion; the partial word is aborted.

## Test plan
- Shift 0xDEADBEEF MSB-first with `enable`=1 for 32 edges and `out_ready`=0 -> `out_valid` rises the next cycle, `out_word`=0xDEADBEEF, `bit_count`=0, `overrun`=0.
- Abort: 10 bits of 0xFFFFFFFF, `enable`=0 for one edge, then a full 0x12345678 -> `out_word`=0x12345678; no word is produced for the partial.
- Overrun: two back-to-back words 0xA5A5A5A5 then 0x0F0F0F0F with `out_ready`=0 -> `out_word` stays 0xA5A5A5A5 and `overrun`=1. Then pulse `clear_overrun` -> `overrun`=0.
- Simultaneous consume and complete: `out_ready`=1 on the completion edge of the second word -> `out_valid` stays 1, `out_word`=second word, `overrun`=0.
- Async reset asserted between clock edges after 17 bits -> `bit_count`, `out_valid`, and `overrun` go to 0 immediately. A subsequent full 0xCAFEF00D is captured correctly.
- WIDTH=8 instance: stream 0x81 then 0x7E continuously with `out_ready`=1 -> two words are produced 8 cycles apart and `overrun` never sets.
